// File: rtl/stage_sequencer_pkg.sv
// stage_sequencer_pkg: shared constants for the multicycle stage sequencer
package stage_sequencer_pkg;
   localparam int OP_W    = 6;
   localparam int FUNCT_W = 6;
   localparam int STG_IF  = 0;
   localparam int STG_ID  = 1;
   localparam int STG_EX  = 2;
   localparam int STG_MEM = 3;
   localparam int STG_WB  = 4;
   localparam logic [2:0] MASK_EX_MEM_WB = 3'b111;
   localparam logic [2:0] MASK_EX_MEM    = 3'b011;
   localparam logic [2:0] MASK_EX_WB     = 3'b101;
   localparam logic [2:0] MASK_ONLY_EX   = 3'b001;
   localparam logic [2:0] MASK_NONE      = 3'b000;
   localparam logic [2:0] MASK_ONLY_WB   = 3'b100;
   localparam logic [OP_W-1:0] OP_R_R   = 6'h00;
   localparam logic [OP_W-1:0] OP_REGIMM = 6'h01;
   localparam logic [OP_W-1:0] OP_J     = 6'h02;
   localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
   localparam logic [OP_W-1:0] OP_BLEZ  = 6'h06;
   localparam logic [OP_W-1:0] OP_BGTZ  = 6'h07;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
   localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
   localparam logic [OP_W-1:0] OP_SLTI  = 6'h0a;
   localparam logic [OP_W-1:0] OP_SLTIU = 6'h0b;
   localparam logic [OP_W-1:0] OP_ANDI  = 6'h0c;
   localparam logic [OP_W-1:0] OP_ORI   = 6'h0d;
   localparam logic [OP_W-1:0] OP_XORI  = 6'h0e;
   localparam logic [OP_W-1:0] OP_LUI   = 6'h0f;
   localparam logic [OP_W-1:0] OP_LB    = 6'h20;
   localparam logic [OP_W-1:0] OP_LH    = 6'h21;
   localparam logic [OP_W-1:0] OP_LW    = 6'h23;
   localparam logic [OP_W-1:0] OP_LBU   = 6'h24;
   localparam logic [OP_W-1:0] OP_LHU   = 6'h25;
   localparam logic [OP_W-1:0] OP_SB    = 6'h28;
   localparam logic [OP_W-1:0] OP_SH    = 6'h29;
   localparam logic [OP_W-1:0] OP_SW    = 6'h2b;
   localparam logic [FUNCT_W-1:0] FN_JR = 6'h08;
   typedef enum logic {RUN, HALTED} seq_state_t;
endpackage

// File: rtl/stage_sequencer_if.sv
// stage_sequencer_if: decoder-side inputs and stage-enable outputs of the sequencer
interface stage_sequencer_if #(
   parameter int N_STAGES = 5,
   parameter int PREFIX_N = 2,
   parameter int RET_W    = 32
);
   import stage_sequencer_pkg::*;
   localparam int SUFFIX_W = N_STAGES - PREFIX_N;
   localparam int IDX_W    = $clog2(N_STAGES);
   logic [OP_W-1:0]     op_code;
   logic [FUNCT_W-1:0]  funct;
   logic [SUFFIX_W-1:0] suffix_mask;
   logic                stall;
   logic                halt;
   logic [N_STAGES-1:0] stage_en;
   logic [IDX_W-1:0]    stage_idx;
   logic                inst_read_en;
   logic                inst_done;
   logic                halted;
   logic [RET_W-1:0]    retired;
   modport master (
      input  op_code, funct, suffix_mask, stall, halt,
      output stage_en, stage_idx, inst_read_en, inst_done, halted, retired
   );
   modport slave (
      output op_code, funct, suffix_mask, stall, halt,
      input  stage_en, stage_idx, inst_read_en, inst_done, halted, retired
   );
endinterface

// File: rtl/stage_mask_decoder.sv
// stage_mask_decoder: maps opcode/funct to the suffix stages (bit0 EX, bit1 MEM, bit2 WB)
module stage_mask_decoder import stage_sequencer_pkg::*; #(
   parameter int SUFFIX_W = 3
) (
   input  logic [OP_W-1:0]     op_code,
   input  logic [FUNCT_W-1:0]  funct,
   output logic [SUFFIX_W-1:0] mask
);
   logic [2:0] m;
   always_comb begin
      case (op_code)
         OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW:            m = MASK_EX_MEM_WB;
         OP_SB, OP_SH, OP_SW:                            m = MASK_EX_MEM;
         OP_R_R:                                         m = (funct == FN_JR) ? MASK_ONLY_EX : MASK_EX_WB;
         OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI,
         OP_SLTI, OP_SLTIU, OP_JAL:                      m = MASK_EX_WB;
         OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM:    m = MASK_ONLY_EX;
         OP_J:                                           m = MASK_NONE;
         OP_LUI:                                         m = MASK_ONLY_WB;
         default:                                        m = MASK_EX_MEM_WB;
      endcase
   end
   assign mask = SUFFIX_W'(m);
endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: one-hot stage enable generator running IF/ID then the decoded suffix stages
module stage_sequencer import stage_sequencer_pkg::*; #(
   parameter int N_STAGES = 5,
   parameter int PREFIX_N = 2,
   parameter int EXT_MASK = 0,
   parameter int RET_W    = 32
) (
   input logic               clk,
   input logic               rst,
   stage_sequencer_if.master bus
);
   localparam int SUFFIX_W = N_STAGES - PREFIX_N;
   localparam int IDX_W    = $clog2(N_STAGES);
   seq_state_t          state_q, state_d;
   logic [N_STAGES-1:0] en_q, en_d;
   logic [IDX_W-1:0]    idx_q, idx_d, nxt_idx;
   logic [SUFFIX_W-1:0] mask_q, mask_d, dec_mask, eff_mask, above;
   logic [RET_W-1:0]    ret_q, ret_d;
   logic                done, last_pre;
   generate
      if (EXT_MASK != 0) begin : g_ext
         assign dec_mask = bus.suffix_mask;
      end else begin : g_dec
         stage_mask_decoder #(.SUFFIX_W(SUFFIX_W)) u_dec (
            .op_code (bus.op_code),
            .funct   (bus.funct),
            .mask    (dec_mask)
         );
      end
   endgenerate
   assign last_pre = idx_q == IDX_W'(PREFIX_N - 1);
   // the mask is still being decoded in the last prefix stage, so search it directly
   assign eff_mask = last_pre ? dec_mask : mask_q;
   always_comb begin
      above   = '0;
      nxt_idx = '0;
      for (int i = SUFFIX_W - 1; i >= 0; i--) begin
         above[i] = eff_mask[i] && (i + PREFIX_N > int'(idx_q));
         if (above[i]) nxt_idx = IDX_W'(i + PREFIX_N);
      end
   end
   always_comb begin
      state_d = state_q;
      en_d    = en_q;
      idx_d   = idx_q;
      mask_d  = mask_q;
      ret_d   = ret_q;
      done    = 1'b0;
      if (state_q == HALTED) begin
         if (!bus.halt) begin
            state_d = RUN;
            en_d    = N_STAGES'(1);
            idx_d   = IDX_W'(STG_IF);
         end
      end else if (!bus.stall) begin
         if (last_pre) mask_d = dec_mask;
         if (int'(idx_q) < PREFIX_N - 1) begin
            en_d  = en_q << 1;
            idx_d = idx_q + 1'b1;
         end else if (|above) begin
            en_d  = N_STAGES'(1) << nxt_idx;
            idx_d = nxt_idx;
         end else begin
            done    = 1'b1;
            ret_d   = ret_q + 1'b1;
            state_d = bus.halt ? HALTED : RUN;
            en_d    = bus.halt ? '0 : N_STAGES'(1);
            idx_d   = IDX_W'(STG_IF);
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         en_q    <= N_STAGES'(1);
         idx_q   <= IDX_W'(STG_IF);
         mask_q  <= '0;
         ret_q   <= '0;
      end else begin
         state_q <= state_d;
         en_q    <= en_d;
         idx_q   <= idx_d;
         mask_q  <= mask_d;
         ret_q   <= ret_d;
      end
   end
   assign bus.stage_en     = en_q;
   assign bus.stage_idx    = idx_q;
   assign bus.inst_read_en = en_q[0];
   assign bus.inst_done    = done & ~rst;
   assign bus.halted       = state_q == HALTED;
   assign bus.retired      = ret_q;
endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: directed vectors with a queue scoreboard checked by a negedge monitor
module tb_stage_sequencer;
   typedef struct {
      bit         sel;
      logic [5:0] en;
      logic       d;
      logic       hl;
      int         ret;
   } exp_t;
   exp_t       sb[$];
   exp_t       e;
   logic       clk = 0, rst = 0, stall = 0, halt = 0;
   logic [5:0] op = 0, fn = 0;
   logic [3:0] smask = 0;
   int         checks = 0, errors = 0;
   int         ei;
   always #5 clk = ~clk;
   stage_sequencer_if #(.N_STAGES(5), .PREFIX_N(2), .RET_W(32)) if_a();
   stage_sequencer_if #(.N_STAGES(6), .PREFIX_N(2), .RET_W(32)) if_b();
   assign if_a.op_code     = op;
   assign if_a.funct       = fn;
   assign if_a.suffix_mask = 3'b000;
   assign if_a.stall       = stall;
   assign if_a.halt        = halt;
   assign if_b.op_code     = op;
   assign if_b.funct       = fn;
   assign if_b.suffix_mask = smask;
   assign if_b.stall       = stall;
   assign if_b.halt        = halt;
   stage_sequencer #(.N_STAGES(5), .PREFIX_N(2), .EXT_MASK(0), .RET_W(32)) dut_a (
      .clk(clk), .rst(rst), .bus(if_a.master));
   stage_sequencer #(.N_STAGES(6), .PREFIX_N(2), .EXT_MASK(1), .RET_W(32)) dut_b (
      .clk(clk), .rst(rst), .bus(if_b.master));
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", n, act, exp, $time);
      end
   endtask
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         e  = sb.pop_front();
         ei = 0;
         for (int i = 0; i < 6; i++) if (e.en[i]) ei = i;
         chk("stage_en",     e.sel ? 32'(if_b.stage_en)     : 32'(if_a.stage_en),     32'(e.en));
         chk("stage_idx",    e.sel ? 32'(if_b.stage_idx)    : 32'(if_a.stage_idx),    32'(ei));
         chk("inst_read_en", e.sel ? 32'(if_b.inst_read_en) : 32'(if_a.inst_read_en), 32'(e.en[0]));
         chk("inst_done",    e.sel ? 32'(if_b.inst_done)    : 32'(if_a.inst_done),    32'(e.d));
         chk("halted",       e.sel ? 32'(if_b.halted)       : 32'(if_a.halted),       32'(e.hl));
         chk("retired",      e.sel ? if_b.retired           : if_a.retired,           32'(e.ret));
      end
   end
   task automatic v(input bit s, input logic [5:0] o, input logic [5:0] f, input logic st,
                    input logic h, input logic r, input logic [5:0] en, input logic d,
                    input logic hl, input int ret);
      op    = o;
      fn    = f;
      stall = st;
      halt  = h;
      rst   = r;
      sb.push_back('{s, en, d, hl, ret});
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      rst   = 1;
      stall = 0;
      halt  = 0;
      @(posedge clk);
      #1;
      rst = 0;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   initial begin
      do_reset();
      // LW: IF ID EX MEM WB
      v(0, 6'h23, 0, 0, 0, 0, 6'b000001, 0, 0, 0);
      v(0, 6'h23, 0, 0, 0, 0, 6'b000010, 0, 0, 0);
      v(0, 6'h23, 0, 0, 0, 0, 6'b000100, 0, 0, 0);
      v(0, 6'h23, 0, 0, 0, 0, 6'b001000, 0, 0, 0);
      v(0, 6'h23, 0, 0, 0, 0, 6'b010000, 1, 0, 0);
      // J, LUI, JR
      v(0, 6'h02, 0, 0, 0, 0, 6'b000001, 0, 0, 1);
      v(0, 6'h02, 0, 0, 0, 0, 6'b000010, 1, 0, 1);
      v(0, 6'h0f, 0, 0, 0, 0, 6'b000001, 0, 0, 2);
      v(0, 6'h0f, 0, 0, 0, 0, 6'b000010, 0, 0, 2);
      v(0, 6'h0f, 0, 0, 0, 0, 6'b010000, 1, 0, 2);
      v(0, 6'h00, 6'h08, 0, 0, 0, 6'b000001, 0, 0, 3);
      v(0, 6'h00, 6'h08, 0, 0, 0, 6'b000010, 0, 0, 3);
      v(0, 6'h00, 6'h08, 0, 0, 0, 6'b000100, 1, 0, 3);
      // SW with MEM stalled 3 cycles
      v(0, 6'h2b, 0, 0, 0, 0, 6'b000001, 0, 0, 4);
      v(0, 6'h2b, 0, 0, 0, 0, 6'b000010, 0, 0, 4);
      v(0, 6'h2b, 0, 0, 0, 0, 6'b000100, 0, 0, 4);
      v(0, 6'h2b, 0, 1, 0, 0, 6'b001000, 0, 0, 4);
      v(0, 6'h2b, 0, 1, 0, 0, 6'b001000, 0, 0, 4);
      v(0, 6'h2b, 0, 1, 0, 0, 6'b001000, 0, 0, 4);
      v(0, 6'h2b, 0, 0, 0, 0, 6'b001000, 1, 0, 4);
      // ADD with halt raised in EX
      v(0, 6'h00, 6'h20, 0, 0, 0, 6'b000001, 0, 0, 5);
      v(0, 6'h00, 6'h20, 0, 0, 0, 6'b000010, 0, 0, 5);
      v(0, 6'h00, 6'h20, 0, 1, 0, 6'b000100, 0, 0, 5);
      v(0, 6'h00, 6'h20, 0, 1, 0, 6'b010000, 1, 0, 5);
      v(0, 6'h00, 6'h20, 0, 1, 0, 6'b000000, 0, 1, 6);
      v(0, 6'h00, 6'h20, 0, 1, 0, 6'b000000, 0, 1, 6);
      v(0, 6'h00, 6'h20, 0, 0, 0, 6'b000000, 0, 1, 6);
      // BEQ with halt only mid-instruction and a stalled ID
      v(0, 6'h04, 0, 0, 1, 0, 6'b000001, 0, 0, 6);
      v(0, 6'h04, 0, 1, 1, 0, 6'b000010, 0, 0, 6);
      v(0, 6'h04, 0, 0, 1, 0, 6'b000010, 0, 0, 6);
      v(0, 6'h04, 0, 0, 0, 0, 6'b000100, 1, 0, 6);
      // unknown opcode runs all suffix stages
      v(0, 6'h3f, 0, 0, 0, 0, 6'b000001, 0, 0, 7);
      v(0, 6'h3f, 0, 0, 0, 0, 6'b000010, 0, 0, 7);
      v(0, 6'h3f, 0, 0, 0, 0, 6'b000100, 0, 0, 7);
      v(0, 6'h3f, 0, 0, 0, 0, 6'b001000, 0, 0, 7);
      v(0, 6'h3f, 0, 0, 0, 0, 6'b010000, 1, 0, 7);
      // LW aborted by reset in MEM
      v(0, 6'h23, 0, 0, 0, 0, 6'b000001, 0, 0, 8);
      v(0, 6'h23, 0, 0, 0, 0, 6'b000010, 0, 0, 8);
      v(0, 6'h23, 0, 0, 0, 0, 6'b000100, 0, 0, 8);
      v(0, 6'h23, 0, 0, 0, 1, 6'b001000, 0, 0, 8);
      v(0, 6'h02, 0, 0, 0, 0, 6'b000001, 0, 0, 0);
      v(0, 6'h02, 0, 0, 0, 0, 6'b000010, 1, 0, 0);
      v(0, 6'h02, 0, 0, 0, 0, 6'b000001, 0, 0, 1);
      // external mask, six stages
      do_reset();
      smask = 4'b1010;
      v(1, 6'h00, 0, 0, 0, 0, 6'b000001, 0, 0, 0);
      v(1, 6'h00, 0, 0, 0, 0, 6'b000010, 0, 0, 0);
      v(1, 6'h00, 0, 0, 0, 0, 6'b001000, 0, 0, 0);
      v(1, 6'h00, 0, 0, 0, 0, 6'b100000, 1, 0, 0);
      smask = 4'b0000;
      v(1, 6'h00, 0, 0, 0, 0, 6'b000001, 0, 0, 1);
      v(1, 6'h00, 0, 0, 0, 0, 6'b000010, 1, 0, 1);
      v(1, 6'h00, 0, 0, 0, 0, 6'b000001, 0, 0, 2);
      @(negedge clk);
      #1;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Parametrised multicycle stage sequencer for the MIPS32 multicycle core. It replaces the fixed five-stage sub-cycle generator. It issues a registered one-hot stage enable per cycle: IF and ID first, then only the suffix stages the decoded instruction class needs. It adds a stall handshake, an instruction-boundary halt, an external-mask mode and a retired-instruction counter. It sits between the control decoder and every stage's register-enable logic.

## Interface
- N_STAGES, 5, total stages; index 0 = IF, 1 = ID, then EX, MEM, WB.
- PREFIX_N, 2, stages every instruction executes before the suffix decision.
- EXT_MASK, 0, 0 = suffix mask from internal decoder; 1 = from `suffix_mask` port.
- RET_W, 32, width of retired-instruction counter.
- Derived localparams: SUFFIX_W = N_STAGES-PREFIX_N; IDX_W = $clog2(N_STAGES).
- clk  in  1  core clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- op_code  in  `OP_WIDTH  opcode, valid in the last prefix stage.
- funct  in  `FUNCT_WIDTH  R-type funct, valid in the last prefix stage.
- suffix_mask  in  SUFFIX_W  external mask; bit k = stage PREFIX_N+k; used only when EXT_MASK=1.
- stall  in  1  current stage not finished; hold it.
- halt  in  1  stop at the next instruction boundary.
- stage_en  out  N_STAGES  registered one-hot active stage; all-zero only when halted.
- stage_idx  out  IDX_W  index of active stage.
- inst_read_en  out  1  equals stage_en[0].
- inst_done  out  1  high during the final, non-stalled stage cycle of an instruction.
- halted  out  1  sequencer idle at a boundary.
- retired  out  RET_W  count of completed instructions; wraps modulo 2^RET_W.

## Operation
- States:
  - RUN: stage_en one-hot.
  - HALTED: stage_en = 0, halted = 1.
- Advance rule:
  - With stall=1, stage_en, stage_idx and the latched mask all hold.
  - With stall=0, the sequencer advances one step per clock.
- Prefix: stage p advances to p+1 for p < PREFIX_N-1.
- Mask latch: in the last prefix stage with stall=0, latch the mask (decoder or port).
- Next stage: lowest set mask bit above the current stage. If no bit remains, the current cycle is the last stage of the instruction. Mask 0 means the instruction ends at ID.
- Last stage with stall=0:
  - assert inst_done;
  - retired increments;
  - next state is HALTED if halt=1, else stage 0 (IF).
- HALTED: leave to IF on the first cycle halt=0. halt is ignored mid-instruction.
- Decoder mask bits: bit0 EX, bit1 MEM, bit2 WB.
  - LB/LBU/LH/LHU/LW = 3'b111.
  - SB/SH/SW = 3'b011.
  - R_R (except JR), ADDI/ADDIU/ANDI/ORI/XORI/SLTI/SLTIU, JAL = 3'b101.
  - JR, BEQ/BNE/BLEZ/BGTZ/BGEZ_BLTZ = 3'b001.
  - J = 3'b000.
  - LUI = 3'b100.
  - Unknown opcode = 3'b111.
- Reset value, applied on the first edge with rst=1:
  - stage_en = 1 (IF), stage_idx = 0;
  - mask = 0, state RUN;
  - inst_done = 0, halted = 0, retired = 0.
- Reset mid-instruction: abort the instruction with no inst_done and no retire; restart at IF.
- rst dominates stall and halt.

## Timing
- All outputs are registered except inst_read_en, which is an alias, and inst_done, which is combinational from state and stall.
- Stage enables are level signals for a full cycle. There are no gated or derived clocks.
- Unstalled instruction latency = PREFIX_N + popcount(mask) cycles. Examples: LW 5, SW 4, ADD 4, BEQ 3, LUI 3, J 2.
- Each stalled cycle extends the current stage by exactly one cycle.
- op_code and funct are sampled only at the clock edge that leaves the last prefix stage.
- Halt-to-halted latency: the cycle after inst_done. Resume: IF on the cycle after halt falls.

## Structure
- Shared package (extend defines.v or add seq_pkg): stage index constants (STG_IF..STG_WB) and suffix mask constants (MASK_EX_MEM_WB, MASK_EX_MEM, MASK_EX_WB, MASK_ONLY_EX, MASK_NONE, MASK_ONLY_WB).
- Sub-module `stage_mask_decoder`: combinational op_code/funct to SUFFIX_W mask. It is bypassed by a generate block when EXT_MASK=1.
- Next-stage search: priority encoder over (mask & bits above current suffix index).

## Test plan
- Reset, then LW (op 6'h23) with no stall -> stage_en 00001,00010,00100,01000,10000, then 00001; inst_done only in the 10000 cycle; retired=1.
- J (6'h02), then LUI (6'h0f), then JR (op 0, funct 6'h08) -> IF,ID,IF; IF,ID,WB,IF; IF,ID,EX,IF; retired=3.
- SW (6'h2b) with stall high for 3 cycles in MEM -> 01000 held 4 cycles; inst_done only on the final MEM cycle; total 7 cycles.
- halt raised during EX of ADD -> EX, WB complete; then stage_en=0 and halted=1 until halt falls; IF the next cycle.
- rst asserted during MEM of LW -> next cycle stage_en=00001, inst_done never pulsed, retired unchanged at 0.
- EXT_MASK=1, N_STAGES=6, suffix_mask=4'b1010 -> IF,ID,stage3,stage5,IF; latency 4.
